rn_word_buffer: RTL

- Downstream consumer of the CA PRNG's selected output cell.
- Takes the generator's serial random bit stream and packs it into non-overlapping N-bit words, so no bit is reused.
- Buffers the packed words in a small first-word-fall-through FIFO and hands them to a consumer over a valid/ready handshake.
- Counts words lost to overflow.

---
 rtl/rn_word_buffer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rn_word_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : rn_word_buffer
//  Purpose  : Packs the serial random bit stream of the CA PRNG's selected
//             output cell into non-overlapping N-bit words. The words are
//             buffered in a small first-word-fall-through FIFO and handed to
//             a consumer over a valid/ready handshake. Words that arrive
//             while the FIFO is full are dropped and counted.
//  Ports    :
//     i_clk       in   1             clock, rising edge
//     i_rst       in   1             asynchronous active-high reset
//     i_clr       in   1             synchronous clear of collector, FIFO and
//                                    drop counter
//     i_en        in   1             i_bit carries a fresh generator bit
//     i_bit       in   1             serial random bit
//     i_ready     in   1             consumer accepts o_word this cycle
//     o_valid     out  1             FIFO not empty
//     o_word      out  N             head-of-FIFO word
//     o_full      out  1             FIFO holds DEPTH words
//     o_level     out  clog2(D)+1    number of stored words
//     o_drop_cnt  out  CNT_W         saturating count of dropped words
//  Revision : 1.0  initial release
// ============================================================================
module rn_word_buffer #(
   parameter int N     = 10,   // word width, >= 2
   parameter int DEPTH = 4,    // FIFO depth, power of 2, >= 2
   parameter int CNT_W = 8     // drop counter width
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_clr,
   input  logic                       i_en,
   input  logic                       i_bit,
   input  logic                       i_ready,
   output logic                       o_valid,
   output logic [N-1:0]               o_word,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_level,
   output logic [CNT_W-1:0]           o_drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(N);

   localparam logic [CW-1:0]    LAST_BIT  = CW'(N - 1);
   localparam logic [CW-1:0]    PENULT    = CW'(N - 2);
   localparam logic [LW-1:0]    FULL_LVL  = LW'(DEPTH);
   localparam logic [CNT_W-1:0] DROP_MAX  = '1;

   // ------------------------------------------------------------------------
   // Collector state. EMIT means the next enabled bit completes a word.
   // ------------------------------------------------------------------------
   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_t;

   state_t            state;
   logic [N-1:0]      sr;
   logic [CW-1:0]     bit_cnt;

   // FIFO storage and bookkeeping
   logic [N-1:0]      mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [LW-1:0]     level;
   logic [CNT_W-1:0]  drop_cnt;
   logic              valid_q;
   logic              full_q;

   // Combinational handshake decode
   logic              push_req;
   logic              pop;
   logic              push_ok;
   logic              drop;
   logic [N-1:0]      word_in;
   logic [LW-1:0]     level_next;

   always_comb begin
      push_req   = 1'b0;
      pop        = 1'b0;
      push_ok    = 1'b0;
      drop       = 1'b0;
      word_in    = {i_bit, sr[N-1:1]};
      level_next = level;

      push_req = i_en && (state == EMIT);
      pop      = (level != '0) && i_ready;
      // A full FIFO still accepts a word when the head leaves in the same
      // cycle: the write lands in the slot being vacated.
      push_ok  = push_req && ((level != FULL_LVL) || pop);
      drop     = push_req && (level == FULL_LVL) && !pop;

      if (push_ok && !pop) begin
         level_next = level + LW'(1);
      end else if (!push_ok && pop) begin
         level_next = level - LW'(1);
      end
   end

   // ------------------------------------------------------------------------
   // Collector FSM: shifts new bits in at the top so the first bit of a word
   // settles in bit 0. The completing bit is pushed directly from i_bit,
   // which lets words run back-to-back with no idle cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= COLLECT;
         sr      <= '0;
         bit_cnt <= '0;
      end else if (i_clr) begin
         state   <= COLLECT;
         sr      <= '0;
         bit_cnt <= '0;
      end else if (i_en) begin
         sr <= word_in;
         if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            state   <= COLLECT;
         end else begin
            bit_cnt <= bit_cnt + CW'(1);
            state   <= (bit_cnt == PENULT) ? EMIT : COLLECT;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FIFO storage. Cleared on reset so the head word reads as zero out of
   // reset; i_clr only resets the pointers.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (!i_clr && push_ok) begin
         mem[wr_ptr] <= word_in;
      end
   end

   // ------------------------------------------------------------------------
   // Pointers, level and the flags derived from the next level so that
   // o_valid / o_full / o_level are all registered and agree every cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         drop_cnt <= '0;
      end else if (i_clr) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level   <= level_next;
         valid_q <= (level_next != '0);
         full_q  <= (level_next == FULL_LVL);
         if (drop && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

   assign o_valid    = valid_q;
   assign o_full     = full_q;
   assign o_level    = level;
   assign o_word     = mem[rd_ptr];
   assign o_drop_cnt = drop_cnt;

endmodule
`default_nettype wire
